io_tape_dev: RTL and testbench

- Character-level device stage that sits directly on the device side of the I/O electronic unit: tape reader (feeds input codes) plus tape punch (consumes output codes).
- Buffers 5-bit codes between a host stream port and the unit's two four-phase handshakes: input rdy/val and output rdy/ack.
- The host stream port is a simulation/test driver or an external link.
- Decouples host timing from the unit and enforces an inter-character gap on the reader side.

---
 rtl/io_codes_pkg.sv | 23 ++
 rtl/io_char_fifo.sv | 71 +++++++
 rtl/io_tape_dev.sv | 164 ++++++++++++++++
 tb/tb_io_tape_dev.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_codes_pkg.sv
// Shared definitions for the I/O character blocks: code width, the
// recognised control codes and the state encodings of the tape stage FSMs.
package io_codes_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] CODE_SEL      = 5'b00001;
    localparam logic [CODE_W-1:0] CODE_WRITE    = 5'b00110;
    localparam logic [CODE_W-1:0] CODE_END      = 5'b00111;
    localparam logic [CODE_W-1:0] CODE_NUM_MASK = 5'b10000;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_VAL  = 2'd1,
        R_GAP  = 2'd2
    } rd_state_e;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_ACK  = 1'b1
    } pn_state_e;

endpackage

// File: rtl/io_char_fifo.sv
// Registered character FIFO (no fall-through). Full/empty come from the
// registered level, so a push into a full FIFO is refused even when a pop
// happens in the same cycle.
module io_char_fifo
    import io_codes_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [CODE_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic [CODE_W-1:0]      head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              push_ok, pop_ok;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/io_tape_dev.sv
// Tape reader / tape punch device stage. Buffers 5-bit codes between the
// host stream port and the I/O unit's rdy/val (reader) and rdy/ack (punch)
// level handshakes, and spaces reader characters by GAP_CYCLES idle cycles.
//
//   state  | meaning
//   R_IDLE | waiting for a buffered code and a ready unit
//   R_VAL  | val high, code held until the unit drops rdy
//   R_GAP  | enforced idle gap after a character
//   P_IDLE | waiting for the unit to present a code
//   P_ACK  | code captured, ack held until the unit drops rdy
module io_tape_dev
    import io_codes_pkg::*;
#(
    parameter int IN_DEPTH   = 16,
    parameter int OUT_DEPTH  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_in_valid,
    output logic                       host_in_ready,
    input  logic [CODE_W-1:0]          host_in_data,
    input  logic                       input_rdy_from_io,
    output logic                       input_val_to_io,
    output logic [CODE_W-1:0]          input_data_to_io,
    input  logic                       output_rdy_from_io,
    input  logic [CODE_W-1:0]          output_data_from_io,
    output logic                       output_ack_to_io,
    output logic                       host_out_valid,
    input  logic                       host_out_ready,
    output logic [CODE_W-1:0]          host_out_data,
    output logic [$clog2(IN_DEPTH):0]  in_level,
    output logic [$clog2(OUT_DEPTH):0] out_level
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    logic              in_full, in_empty, in_pop;
    logic [CODE_W-1:0] in_head;
    logic              out_full, out_empty, out_push, out_pop;

    rd_state_e         rd_state_q, rd_state_d;
    logic              val_q, val_d;
    logic [CODE_W-1:0] data_q, data_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    pn_state_e         pn_state_q, pn_state_d;
    logic              ack_q, ack_d;

    assign host_in_ready    = !in_full;
    assign host_out_valid   = !out_empty;
    assign out_pop          = host_out_ready && !out_empty;
    assign input_val_to_io  = val_q;
    assign input_data_to_io = data_q;
    assign output_ack_to_io = ack_q;

    io_char_fifo #(.DEPTH(IN_DEPTH)) u_rd_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (host_in_valid),
        .push_data_i (host_in_data),
        .pop_i       (in_pop),
        .head_o      (in_head),
        .full_o      (in_full),
        .empty_o     (in_empty),
        .level_o     (in_level)
    );

    io_char_fifo #(.DEPTH(OUT_DEPTH)) u_pn_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .push_i      (out_push),
        .push_data_i (output_data_from_io),
        .pop_i       (out_pop),
        .head_o      (host_out_data),
        .full_o      (out_full),
        .empty_o     (out_empty),
        .level_o     (out_level)
    );

    // Reader next-state: the FIFO entry is only popped once the unit has
    // dropped rdy, i.e. after it has latched the held code.
    always_comb begin
        rd_state_d = rd_state_q;
        val_d      = val_q;
        data_d     = data_q;
        gap_d      = gap_q;
        in_pop     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (!in_empty && input_rdy_from_io) begin
                    data_d     = in_head;
                    val_d      = 1'b1;
                    rd_state_d = R_VAL;
                end
            end
            R_VAL: begin
                if (!input_rdy_from_io) begin
                    in_pop     = 1'b1;
                    val_d      = 1'b0;
                    gap_d      = GAP_LOAD;
                    rd_state_d = (GAP_CYCLES == 0) ? R_IDLE : R_GAP;
                end
            end
            R_GAP: begin
                gap_d = gap_q - GAP_ONE;
                if (gap_q == GAP_ONE) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Reader state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            val_q      <= 1'b0;
            data_q     <= '0;
            gap_q      <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            val_q      <= val_d;
            data_q     <= data_d;
            gap_q      <= gap_d;
        end
    end

    // Punch next-state: one capture per rdy assertion, refused while full.
    always_comb begin
        pn_state_d = pn_state_q;
        ack_d      = ack_q;
        out_push   = 1'b0;
        case (pn_state_q)
            P_IDLE: begin
                if (output_rdy_from_io && !out_full) begin
                    out_push   = 1'b1;
                    ack_d      = 1'b1;
                    pn_state_d = P_ACK;
                end
            end
            P_ACK: begin
                if (!output_rdy_from_io) begin
                    ack_d      = 1'b0;
                    pn_state_d = P_IDLE;
                end
            end
            default: pn_state_d = P_IDLE;
        endcase
    end

    // Punch state and registered acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pn_state_q <= P_IDLE;
            ack_q      <= 1'b0;
        end else begin
            pn_state_q <= pn_state_d;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: tb/tb_io_tape_dev.sv
// Bench for io_tape_dev: scoreboard queues filled at stimulus time, drained
// by monitors that watch val rises (reader) and host pops (punch).
module tb_io_tape_dev;
    import io_codes_pkg::*;

    localparam int GAP = 2;

    logic       clk;
    logic       reset;
    logic       host_in_valid;
    logic       host_in_ready;
    logic [4:0] host_in_data;
    logic       input_rdy_from_io;
    logic       input_val_to_io;
    logic [4:0] input_data_to_io;
    logic       output_rdy_from_io;
    logic [4:0] output_data_from_io;
    logic       output_ack_to_io;
    logic       host_out_valid;
    logic       host_out_ready;
    logic [4:0] host_out_data;
    logic [4:0] in_level;
    logic [4:0] out_level;

    int errors;
    int checks;
    bit auto_unit;
    bit gap_chk_en;
    logic [4:0] rd_exp[$];
    logic [4:0] pn_exp[$];

    io_tape_dev #(.IN_DEPTH(16), .OUT_DEPTH(16), .GAP_CYCLES(GAP)) dut (
        .clk                 (clk),
        .reset               (reset),
        .host_in_valid       (host_in_valid),
        .host_in_ready       (host_in_ready),
        .host_in_data        (host_in_data),
        .input_rdy_from_io   (input_rdy_from_io),
        .input_val_to_io     (input_val_to_io),
        .input_data_to_io    (input_data_to_io),
        .output_rdy_from_io  (output_rdy_from_io),
        .output_data_from_io (output_data_from_io),
        .output_ack_to_io    (output_ack_to_io),
        .host_out_valid      (host_out_valid),
        .host_out_ready      (host_out_ready),
        .host_out_data       (host_out_data),
        .in_level            (in_level),
        .out_level           (out_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One host push attempt; expectation of acceptance is supplied by caller.
    task automatic host_push(input logic [4:0] c, input bit accept);
        host_in_valid = 1'b1;
        host_in_data  = c;
        smp();
        chk("host_in_ready", host_in_ready, accept);
        if (accept) rd_exp.push_back(c);
        tick();
        host_in_valid = 1'b0;
    endtask

    task automatic wait_rd_drain(input int budget);
        int n;
        n = 0;
        while (rd_exp.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (rd_exp.size() != 0) begin
            errors++;
            $display("FAIL rd_drain_timeout: got %0d codes outstanding want 0", rd_exp.size());
        end
    endtask

    task automatic wait_pn_drain(input int budget);
        int n;
        n = 0;
        while (pn_exp.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (pn_exp.size() != 0) begin
            errors++;
            $display("FAIL pn_drain_timeout: got %0d codes outstanding want 0", pn_exp.size());
        end
    endtask

    // Unit model: drops rdy once it sees val, raises it again once val is low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_unit) begin
                if (input_val_to_io && input_rdy_from_io) input_rdy_from_io = 1'b0;
                else input_rdy_from_io = 1'b1;
            end
        end
    end

    // Reader monitor: each val rise must carry the next expected code.
    initial begin
        logic       vp;
        logic [4:0] held;
        int         low_run;
        bit         seen_fall;
        vp = 1'b0; held = '0; low_run = 0; seen_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                vp = 1'b0; low_run = 0; seen_fall = 1'b0;
            end else begin
                if (input_val_to_io && !vp) begin
                    if (rd_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_extra: got code %b want no character", input_data_to_io);
                    end else begin
                        held = rd_exp.pop_front();
                        chk("rd_data", input_data_to_io, held);
                    end
                    // gap cycles plus the idle cycle that re-arms val
                    if (gap_chk_en && seen_fall) chk("rd_gap_low_cycles", low_run, GAP + 1);
                    low_run = 0;
                end else if (input_val_to_io) begin
                    chk("rd_hold", input_data_to_io, held);
                end else begin
                    if (vp) begin
                        seen_fall = gap_chk_en;
                        low_run   = 0;
                    end
                    low_run++;
                end
                vp = input_val_to_io;
            end
        end
    end

    // Punch monitor: every host pop must deliver the next expected code.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && host_out_valid && host_out_ready) begin
                if (pn_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pn_extra: got code %b want no code", host_out_data);
                end else begin
                    chk("pn_data", host_out_data, pn_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] c;
        errors = 0; checks = 0; auto_unit = 1'b0; gap_chk_en = 1'b0;
        reset = 1'b1;
        host_in_valid = 1'b0; host_in_data = '0;
        input_rdy_from_io = 1'b0;
        output_rdy_from_io = 1'b0; output_data_from_io = '0;
        host_out_ready = 1'b0;

        // reset values
        smp();
        chk("rst_val", input_val_to_io, 0);
        chk("rst_data", input_data_to_io, 0);
        chk("rst_ack", output_ack_to_io, 0);
        chk("rst_in_ready", host_in_ready, 1);
        chk("rst_out_valid", host_out_valid, 0);
        chk("rst_in_level", in_level, 0);
        chk("rst_out_level", out_level, 0);
        tick();
        reset = 1'b0;
        tick();

        // single character, unit holding rdy high
        input_rdy_from_io = 1'b1;
        host_push(5'b10011, 1'b1);
        smp();
        chk("t1_val_after_push", input_val_to_io, 0);
        chk("t1_in_level", in_level, 1);
        smp();
        chk("t1_val_2_cycles", input_val_to_io, 1);
        input_rdy_from_io = 1'b0;
        smp();
        chk("t1_val_dropped", input_val_to_io, 0);
        chk("t1_in_level_empty", in_level, 0);
        tick();

        // three characters with gap spacing
        auto_unit = 1'b1;
        gap_chk_en = 1'b1;
        host_push(5'b10001, 1'b1);
        host_push(CODE_WRITE, 1'b1);
        host_push(CODE_END, 1'b1);
        wait_rd_drain(60);
        repeat (6) tick();
        gap_chk_en = 1'b0;
        auto_unit = 1'b0;
        input_rdy_from_io = 1'b0;
        smp();
        chk("t2_in_level", in_level, 0);
        tick();

        // fill reader FIFO, refuse 17th, then drain in order
        for (int i = 0; i < 16; i++) begin
            c = 5'(i * 7 + 3);
            host_push(c, 1'b1);
        end
        host_push(5'b11110, 1'b0);
        smp();
        chk("t3_in_level_full", in_level, 16);
        tick();
        auto_unit = 1'b1;
        wait_rd_drain(200);
        repeat (10) tick();
        auto_unit = 1'b0;
        input_rdy_from_io = 1'b0;
        smp();
        chk("t3_in_level_drained", in_level, 0);
        chk("t3_val_idle", input_val_to_io, 0);
        tick();

        // punch: two codes through rdy/ack, code sampled once per handshake
        output_rdy_from_io = 1'b1;
        output_data_from_io = 5'b11111;
        pn_exp.push_back(5'b11111);
        smp();
        chk("t4_ack_before", output_ack_to_io, 0);
        tick();
        output_data_from_io = 5'b01010;
        smp();
        chk("t4_ack_rise", output_ack_to_io, 1);
        chk("t4_out_valid", host_out_valid, 1);
        tick();
        smp();
        chk("t4_ack_hold", output_ack_to_io, 1);
        chk("t4_single_push", out_level, 1);
        tick();
        output_rdy_from_io = 1'b0;
        smp();
        chk("t4_ack_hold_rdy_low", output_ack_to_io, 1);
        tick();
        smp();
        chk("t4_ack_fall", output_ack_to_io, 0);
        tick();
        output_rdy_from_io = 1'b1;
        output_data_from_io = 5'b10101;
        pn_exp.push_back(5'b10101);
        tick();
        smp();
        chk("t4_ack_rise2", output_ack_to_io, 1);
        chk("t4_out_level2", out_level, 2);
        tick();
        output_rdy_from_io = 1'b0;
        tick();
        smp();
        chk("t4_ack_fall2", output_ack_to_io, 0);
        tick();
        host_out_ready = 1'b1;
        wait_pn_drain(20);
        host_out_ready = 1'b0;
        smp();
        chk("t4_out_level_drained", out_level, 0);
        tick();

        // punch back-pressure when full
        for (int i = 0; i < 16; i++) begin
            c = 5'(i * 5 + 1);
            output_rdy_from_io = 1'b1;
            output_data_from_io = c;
            pn_exp.push_back(c);
            tick();
            output_rdy_from_io = 1'b0;
            tick();
        end
        output_rdy_from_io = 1'b1;
        output_data_from_io = 5'b11100;
        repeat (3) tick();
        smp();
        chk("t5_ack_full", output_ack_to_io, 0);
        chk("t5_out_level_full", out_level, 16);
        tick();
        host_out_ready = 1'b1;
        tick();
        host_out_ready = 1'b0;
        smp();
        chk("t5_ack_pop_cycle", output_ack_to_io, 0);
        chk("t5_out_level_15", out_level, 15);
        pn_exp.push_back(5'b11100);
        tick();
        smp();
        chk("t5_ack_after_pop", output_ack_to_io, 1);
        chk("t5_out_level_16", out_level, 16);
        tick();
        output_rdy_from_io = 1'b0;
        tick();
        host_out_ready = 1'b1;
        wait_pn_drain(40);
        host_out_ready = 1'b0;
        smp();
        chk("t5_out_level_drained", out_level, 0);
        tick();

        // reset in the middle of both handshakes
        input_rdy_from_io = 1'b1;
        host_push(CODE_END, 1'b1);
        host_in_valid = 1'b1;
        host_in_data = CODE_SEL;
        output_rdy_from_io = 1'b1;
        output_data_from_io = 5'b01100;
        tick();
        host_in_valid = 1'b0;
        smp();
        chk("t6_val_before_rst", input_val_to_io, 1);
        chk("t6_ack_before_rst", output_ack_to_io, 1);
        chk("t6_in_level_before_rst", in_level, 2);
        chk("t6_out_level_before_rst", out_level, 1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_val", input_val_to_io, 0);
        chk("t6_rst_data", input_data_to_io, 0);
        chk("t6_rst_ack", output_ack_to_io, 0);
        chk("t6_rst_in_level", in_level, 0);
        chk("t6_rst_out_level", out_level, 0);
        chk("t6_rst_in_ready", host_in_ready, 1);
        chk("t6_rst_out_valid", host_out_valid, 0);
        output_rdy_from_io = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        host_push(5'b01001, 1'b1);
        auto_unit = 1'b1;
        wait_rd_drain(20);
        repeat (6) tick();
        auto_unit = 1'b0;
        input_rdy_from_io = 1'b0;
        smp();
        chk("t6_post_val", input_val_to_io, 0);
        chk("t6_post_in_level", in_level, 0);
        tick();
        output_rdy_from_io = 1'b1;
        output_data_from_io = CODE_WRITE;
        pn_exp.push_back(CODE_WRITE);
        tick();
        smp();
        chk("t6_post_ack", output_ack_to_io, 1);
        tick();
        output_rdy_from_io = 1'b0;
        tick();
        smp();
        chk("t6_post_ack_fall", output_ack_to_io, 0);
        tick();
        host_out_ready = 1'b1;
        wait_pn_drain(20);
        host_out_ready = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
